array_divider: RTL and testbench

- Fully pipelined unsigned restoring array divider.
- Computes quotient and remainder of A / B with throughput of one operation per clock.
- Fixed latency set by a parameter.
- Used as an arithmetic datapath block and as a register-retiming target: pipeline registers may be placed anywhere along the DATAWIDTH subtract rows, provided the latency and the results are unchanged.

---
 rtl/array_divider.sv | 123 ++++++++++++
 tb/tb_array_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/array_divider.sv
// Fully pipelined unsigned restoring array divider: one subtract row per quotient bit, MSB first.
// Register boundaries are spread evenly over the rows; the last one always drives the outputs.
module array_divider #(
  parameter int DATAWIDTH           = 16,
  parameter int NUM_PIPELINE_STAGES = 17,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATAWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] B,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] Q_out,
  output logic [DATAWIDTH-1:0] R_out
);

  localparam int W = DATAWIDTH;
  localparam int S = NUM_PIPELINE_STAGES;

  // Boundary k (1..S) sits after floor(k*W/S) rows; positions are distinct for 1 <= S <= W+1,
  // so the first boundary lands on the inputs when S = W+1 and the last always lands after row W.
  function automatic logic has_boundary(input int pos);
    logic hit;
    hit = 1'b0;
    for (int k = 1; k <= S; k++) begin
      hit = hit | (((k * W) / S) == pos);
    end
    return hit;
  endfunction

  // Position p = number of rows already applied; *_in_s is before the optional register, *_out_s after.
  logic         vld_in_s  [0:W];
  logic         vld_out_s [0:W];
  logic [W-1:0] q_in_s    [0:W];
  logic [W-1:0] q_out_s   [0:W];
  logic [W-1:0] p_in_s    [0:W];
  logic [W-1:0] p_out_s   [0:W];
  logic [W-1:0] a_in_s    [0:W-1];
  logic [W-1:0] a_out_s   [0:W-1];
  logic [W-1:0] b_in_s    [0:W-1];
  logic [W-1:0] b_out_s   [0:W-1];

  assign vld_in_s[0] = i_valid;
  assign a_in_s[0]   = A;
  assign b_in_s[0]   = B;
  assign q_in_s[0]   = {W{1'b0}};
  assign p_in_s[0]   = {W{1'b0}};

  for (genvar p = 0; p <= W; p++) begin : g_pos
    if (has_boundary(p)) begin : g_reg
      logic         vld_r;
      logic [W-1:0] q_r;
      logic [W-1:0] p_r;

      // Valid bit, partial quotient and partial remainder stage register.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_r <= 1'b0;
          q_r   <= {W{1'b0}};
          p_r   <= {W{1'b0}};
        end else begin
          vld_r <= vld_in_s[p];
          q_r   <= q_in_s[p];
          p_r   <= p_in_s[p];
        end
      end

      assign vld_out_s[p] = vld_r;
      assign q_out_s[p]   = q_r;
      assign p_out_s[p]   = p_r;

      if (p < W) begin : g_ab
        logic [W-1:0] a_r;
        logic [W-1:0] b_r;

        // Operands ride along with their partial results.
        always_ff @(posedge clk) begin
          if (rst) begin
            a_r <= {W{1'b0}};
            b_r <= {W{1'b0}};
          end else begin
            a_r <= a_in_s[p];
            b_r <= b_in_s[p];
          end
        end

        assign a_out_s[p] = a_r;
        assign b_out_s[p] = b_r;
      end
    end else begin : g_wire
      assign vld_out_s[p] = vld_in_s[p];
      assign q_out_s[p]   = q_in_s[p];
      assign p_out_s[p]   = p_in_s[p];
      if (p < W) begin : g_ab
        assign a_out_s[p] = a_in_s[p];
        assign b_out_s[p] = b_in_s[p];
      end
    end

    if (p < W) begin : g_row
      logic [W:0] shift_s;
      logic [W:0] diff_s;

      // Partial remainder never exceeds W bits, so the W+1-bit difference MSB is the sign.
      assign shift_s = {p_out_s[p], a_out_s[p][W-1-p]};
      assign diff_s  = shift_s - {1'b0, b_out_s[p]};

      assign p_in_s[p+1]   = diff_s[W] ? shift_s[W-1:0] : diff_s[W-1:0];
      assign q_in_s[p+1]   = {q_out_s[p][W-2:0], ~diff_s[W]};
      assign vld_in_s[p+1] = vld_out_s[p];
      if (p + 1 < W) begin : g_fwd
        assign a_in_s[p+1] = a_out_s[p];
        assign b_in_s[p+1] = b_out_s[p];
      end
    end
  end

  assign o_valid = vld_out_s[W];
  assign Q_out   = q_out_s[W];
  assign R_out   = p_out_s[W];

endmodule

// File: tb/tb_array_divider.sv
// Scoreboard bench for array_divider: driver pushes expected results computed with plain
// division, a negedge monitor checks o_valid timing and data for every cycle.
module tb_array_divider;
  localparam int W = 16;
  localparam int S = 17;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         o_valid;
  logic [W-1:0] Q_out;
  logic [W-1:0] R_out;

  array_divider #(.DATAWIDTH(W), .NUM_PIPELINE_STAGES(S), .INSTANCE_ID(3)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .A(A), .B(B),
    .o_valid(o_valid), .Q_out(Q_out), .R_out(R_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle; a valid op is expected to be visible after edge (sample edge + S - 1).
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk); #1;
    rst     = 1'b0;
    i_valid = v;
    A       = a;
    B       = b;
    if (v) begin
      e.a   = a;
      e.b   = b;
      e.q   = (b == 0) ? {W{1'b1}} : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.due = cyc + S;
      sb.push_back(e);
    end
  endtask

  // Hold reset for n cycles with live-looking inputs; everything in flight is lost.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      rst     = 1'b1;
      i_valid = 1'b1;
      A       = W'($urandom);
      B       = W'($urandom);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (cyc > 0) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL stale_result cyc=%0d op %0d/%0d never checked (due %0d)", cyc, e.a, e.b, e.due);
      end
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      n_checks++;
      if (o_valid !== exp_v) begin
        n_fail++;
        $display("FAIL o_valid cyc=%0d got %b want %b", cyc, o_valid, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        if (o_valid === 1'b1) begin
          n_checks++;
          if (Q_out !== e.q || R_out !== e.r) begin
            n_fail++;
            $display("FAIL result cyc=%0d %0d/%0d got Q=%0d R=%0d want Q=%0d R=%0d",
                     cyc, e.a, e.b, Q_out, R_out, e.q, e.r);
          end
        end
      end
    end
  end

  logic [W-1:0] pa [10] = '{16'd1024, 16'd2439, 16'd5, 16'd4, 16'd2, 16'd50, 16'd7, 16'd30, 16'd5, 16'd4};
  logic [W-1:0] pb [10] = '{16'd10,   16'd300,  16'd2, 16'd3, 16'd3, 16'd1,  16'd3, 16'd2,  16'd2, 16'd3};

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           waited;
    rst     = 1'b1;
    i_valid = 1'b0;
    A       = {W{1'b0}};
    B       = {W{1'b0}};
    do_reset(2);

    // Single op after reset, then idle long enough to see it alone.
    drive(1'b1, 16'd1024, 16'd10);
    repeat (S + 2) drive(1'b0, 16'd0, 16'd0);

    // Back-to-back stream, last pair held.
    for (int i = 0; i < 10; i++) drive(1'b1, pa[i], pb[i]);
    repeat (4) drive(1'b1, pa[9], pb[9]);

    // Boundaries, divide by zero, bubbles.
    drive(1'b1, 16'd65535, 16'd65535);
    drive(1'b1, 16'd65535, 16'd1);
    drive(1'b1, 16'd0,     16'd7);
    drive(1'b1, 16'd32768, 16'd3);
    drive(1'b1, 16'd1234,  16'd0);
    drive(1'b1, 16'd100,   16'd7);
    drive(1'b0, 16'd555,   16'd0);
    drive(1'b1, 16'd200,   16'd9);

    // Random traffic with occasional bubbles, zero and tiny divisors.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = {W{1'b0}};
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0), ra, rb);
    end

    // Mid-stream reset discards in-flight work; later ops keep exact latency.
    for (int i = 0; i < 8; i++) drive(1'b1, W'($urandom), W'($urandom_range(1, 255)));
    do_reset(1);
    drive(1'b1, 16'd100, 16'd7);
    drive(1'b1, 16'd200, 16'd9);

    waited = 0;
    while (sb.size() > 0 && waited < 3 * S) begin
      drive(1'b0, 16'd0, 16'd0);
      waited++;
    end
    repeat (3) drive(1'b0, 16'd0, 16'd0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain outstanding=%0d want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
